// File: rtl/piso_shift_reg_if.sv
// piso_shift_reg_if: bundles the parallel-load handshake and the serial-side
// handshake/status of piso_shift_reg.
//   master : the environment (parallel producer + serial sink)
//   slave  : the shift register itself
interface piso_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             busy;
    logic             done;

    modport master (
        output in_data, in_valid, ser_ready,
        input  in_ready, ser_out, ser_valid, busy, done
    );

    modport slave (
        input  in_data, in_valid, ser_ready,
        output in_ready, ser_out, ser_valid, busy, done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parametrised parallel-in/serial-out shift register.
// A WIDTH-bit word is accepted on a valid/ready handshake and emitted one bit
// per accepted serial beat, MSB- or LSB-first; done pulses once per word.
// Optional feature macro: PISO_PARITY_EN appends a parity bit (sense set by
// PARITY_ODD) after the data bits.
// Reset rst is synchronous and active-low. Every output is either a register
// or a decode of the state register, so no input reaches an output
// combinationally.
module piso_shift_reg #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    piso_shift_reg_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]    cnt_reg,   cnt_next;
    logic             done_reg,  done_next;
`ifdef PISO_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    // Shift register moved one place toward the output end, zero-filled at
    // the far end; built per bit so the direction is fixed at elaboration.
    logic [WIDTH-1:0] shifted;
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = shreg_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shifted[gi] = shreg_reg[gi+1];
                end
            end
        end
    endgenerate

    // Next-state logic: load in IDLE, shift per accepted beat, exit after the
    // last bit (through PARITY when that feature is built in).
    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
`ifdef PISO_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    shreg_next = bus.in_data;
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
`ifdef PISO_PARITY_EN
                    parity_next = (^bus.in_data) ^ PARITY_ODD;
`endif
                end
            end
            ST_SHIFT: begin
                if (bus.ser_ready) begin
                    shreg_next = shifted;
                    cnt_next   = cnt_reg + CNT_ONE;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next = '0;
`ifdef PISO_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (bus.ser_ready) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any word in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
`ifdef PISO_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Serial bit decode: output end of the shift register while shifting,
    // stored parity in PARITY, zero otherwise.
    logic ser_out_dec;
    always_comb begin
        ser_out_dec = 1'b0;
        if (state_reg == ST_SHIFT) begin
            ser_out_dec = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];
        end
`ifdef PISO_PARITY_EN
        else if (state_reg == ST_PARITY) begin
            ser_out_dec = parity_reg;
        end
`endif
    end

    assign bus.in_ready  = (state_reg == ST_IDLE);
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.ser_valid = (state_reg != ST_IDLE);
    assign bus.ser_out   = ser_out_dec;
    assign bus.done      = done_reg;

endmodule
